// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings, widths and pipeline-register bundles for the RISC-V control pipeline.
package riscv_ctrl_pkg;

    localparam int unsigned REG_AW   = 5;
    localparam int unsigned ALUCTL_W = 3;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic                reg_write;
        logic                mem_write;
        logic                jump;
        logic                branch;
        logic                alu_src;
        logic [1:0]          result_src;
        logic [ALUCTL_W-1:0] alu_control;
        logic [REG_AW-1:0]   rs1;
        logic [REG_AW-1:0]   rs2;
        logic [REG_AW-1:0]   rd;
    } ctrl_e_t;

    typedef struct packed {
        logic              reg_write;
        logic              mem_write;
        logic [1:0]        result_src;
        logic [REG_AW-1:0] rd;
    } ctrl_m_t;

    typedef struct packed {
        logic              reg_write;
        logic [1:0]        result_src;
        logic [REG_AW-1:0] rd;
    } ctrl_w_t;

    // Only a clean 1 enables; X/Z collapses to 0 so a bad decode never writes or redirects.
    function automatic logic clean_bit(logic b);
        return (b === 1'b1);
    endfunction

endpackage

// File: rtl/ctrl_pipe_hazard_if.sv
// Decode-side inputs and E/M/W control / hazard outputs of the control pipeline.
interface ctrl_pipe_hazard_if;
    import riscv_ctrl_pkg::*;

    logic                RegWriteD;
    logic                MemWriteD;
    logic                JumpD;
    logic                BranchD;
    logic                ALUSrcD;
    logic [1:0]          ResultSrcD;
    logic [ALUCTL_W-1:0] ALUControlD;
    logic [REG_AW-1:0]   Rs1D;
    logic [REG_AW-1:0]   Rs2D;
    logic [REG_AW-1:0]   RdD;
    logic                ZeroE;

    logic [ALUCTL_W-1:0] ALUControlE;
    logic                ALUSrcE;
    logic [REG_AW-1:0]   Rs1E;
    logic [REG_AW-1:0]   Rs2E;
    logic [REG_AW-1:0]   RdE;
    logic                PCSrcE;
    logic                MemWriteM;
    logic [REG_AW-1:0]   RdM;
    logic                RegWriteM;
    logic                RegWriteW;
    logic [1:0]          ResultSrcW;
    logic [REG_AW-1:0]   RdW;
    logic [1:0]          ForwardAE;
    logic [1:0]          ForwardBE;
    logic                StallF;
    logic                StallD;
    logic                FlushD;

    modport master (
        output RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD,
               Rs1D, Rs2D, RdD, ZeroE,
        input  ALUControlE, ALUSrcE, Rs1E, Rs2E, RdE, PCSrcE, MemWriteM, RdM, RegWriteM,
               RegWriteW, ResultSrcW, RdW, ForwardAE, ForwardBE, StallF, StallD, FlushD
    );

    modport slave (
        input  RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD,
               Rs1D, Rs2D, RdD, ZeroE,
        output ALUControlE, ALUSrcE, Rs1E, Rs2E, RdE, PCSrcE, MemWriteM, RdM, RegWriteM,
               RegWriteW, ResultSrcW, RdW, ForwardAE, ForwardBE, StallF, StallD, FlushD
    );

endinterface

// File: rtl/hazard_unit.sv
// Combinational redirect, load-use stall/flush and Execute operand-forwarding logic.
module hazard_unit
    import riscv_ctrl_pkg::*;
(
    input  logic              branch_e_i,
    input  logic              jump_e_i,
    input  logic              zero_e_i,
    input  logic              reg_write_e_i,
    input  logic [1:0]        result_src_e_i,
    input  logic [REG_AW-1:0] rd_e_i,
    input  logic [REG_AW-1:0] rs1_e_i,
    input  logic [REG_AW-1:0] rs2_e_i,
    input  logic [REG_AW-1:0] rs1_d_i,
    input  logic [REG_AW-1:0] rs2_d_i,
    input  logic              reg_write_m_i,
    input  logic [REG_AW-1:0] rd_m_i,
    input  logic              reg_write_w_i,
    input  logic [REG_AW-1:0] rd_w_i,
    output logic              pc_src_e_o,
    output logic              lw_stall_o,
    output logic              flush_e_o,
    output logic [1:0]        forward_a_e_o,
    output logic [1:0]        forward_b_e_o
);

    // Memory stage wins over Writeback: it holds the younger result.
    function automatic logic [1:0] fwd_sel(logic [REG_AW-1:0] rs, logic rw_m,
                                           logic [REG_AW-1:0] rd_m, logic rw_w,
                                           logic [REG_AW-1:0] rd_w);
        if (rw_m && (rd_m != '0) && (rs == rd_m)) begin
            return FWD_MEM;
        end else if (rw_w && (rd_w != '0) && (rs == rd_w)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    always_comb begin
        pc_src_e_o    = (branch_e_i & zero_e_i) | jump_e_i;
        lw_stall_o    = reg_write_e_i && (result_src_e_i == RES_MEM) && (rd_e_i != '0) &&
                        ((rs1_d_i == rd_e_i) || (rs2_d_i == rd_e_i));
        flush_e_o     = lw_stall_o | pc_src_e_o;
        forward_a_e_o = fwd_sel(rs1_e_i, reg_write_m_i, rd_m_i, reg_write_w_i, rd_w_i);
        forward_b_e_o = fwd_sel(rs2_e_i, reg_write_m_i, rd_m_i, reg_write_w_i, rd_w_i);
    end

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// E/M/W control pipeline registers for the five-stage RISC-V core plus its hazard unit.
module ctrl_pipe_hazard
    import riscv_ctrl_pkg::*;
(
    input logic               clk,
    input logic               reset,
    ctrl_pipe_hazard_if.slave bus
);

    ctrl_e_t e_d, e_q;
    ctrl_m_t m_d, m_q;
    ctrl_w_t w_d, w_q;

    logic       pc_src_e;
    logic       lw_stall;
    logic       flush_e;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    hazard_unit u_hazard (
        .branch_e_i    (e_q.branch),
        .jump_e_i      (e_q.jump),
        .zero_e_i      (bus.ZeroE),
        .reg_write_e_i (e_q.reg_write),
        .result_src_e_i(e_q.result_src),
        .rd_e_i        (e_q.rd),
        .rs1_e_i       (e_q.rs1),
        .rs2_e_i       (e_q.rs2),
        .rs1_d_i       (bus.Rs1D),
        .rs2_d_i       (bus.Rs2D),
        .reg_write_m_i (m_q.reg_write),
        .rd_m_i        (m_q.rd),
        .reg_write_w_i (w_q.reg_write),
        .rd_w_i        (w_q.rd),
        .pc_src_e_o    (pc_src_e),
        .lw_stall_o    (lw_stall),
        .flush_e_o     (flush_e),
        .forward_a_e_o (fwd_a),
        .forward_b_e_o (fwd_b)
    );

    always_comb begin
        e_d             = '0;
        e_d.reg_write   = clean_bit(bus.RegWriteD);
        e_d.mem_write   = clean_bit(bus.MemWriteD);
        e_d.jump        = clean_bit(bus.JumpD);
        e_d.branch      = clean_bit(bus.BranchD);
        e_d.alu_src     = bus.ALUSrcD;
        e_d.result_src  = $isunknown(bus.ResultSrcD) ? RES_ALU : bus.ResultSrcD;
        e_d.alu_control = bus.ALUControlD;
        e_d.rs1         = bus.Rs1D;
        e_d.rs2         = bus.Rs2D;
        e_d.rd          = bus.RdD;
        if (flush_e) begin
            e_d = '0;
        end

        m_d.reg_write  = e_q.reg_write;
        m_d.mem_write  = e_q.mem_write;
        m_d.result_src = e_q.result_src;
        m_d.rd         = e_q.rd;

        w_d.reg_write  = m_q.reg_write;
        w_d.result_src = m_q.result_src;
        w_d.rd         = m_q.rd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    assign bus.ALUControlE = e_q.alu_control;
    assign bus.ALUSrcE     = e_q.alu_src;
    assign bus.Rs1E        = e_q.rs1;
    assign bus.Rs2E        = e_q.rs2;
    assign bus.RdE         = e_q.rd;
    assign bus.MemWriteM   = m_q.mem_write;
    assign bus.RdM         = m_q.rd;
    assign bus.RegWriteM   = m_q.reg_write;
    assign bus.RegWriteW   = w_q.reg_write;
    assign bus.ResultSrcW  = w_q.result_src;
    assign bus.RdW         = w_q.rd;

    // Hazard requests are forced idle while reset is held, whatever stale state remains.
    assign bus.PCSrcE    = pc_src_e & ~reset;
    assign bus.FlushD    = pc_src_e & ~reset;
    assign bus.StallF    = lw_stall & ~reset;
    assign bus.StallD    = lw_stall & ~reset;
    assign bus.ForwardAE = reset ? FWD_RF : fwd_a;
    assign bus.ForwardBE = reset ? FWD_RF : fwd_b;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Random and directed stimulus for ctrl_pipe_hazard against an instruction-queue reference model.
module tb_ctrl_pipe_hazard;
    import riscv_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ctrl_pipe_hazard_if bus ();

    ctrl_pipe_hazard dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        bit       rw;
        bit       mw;
        bit       jmp;
        bit       br;
        bit       asrc;
        bit [1:0] rsrc;
        bit [2:0] aluc;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit [4:0] rd;
    } instr_t;

    // In-flight instructions, youngest first: [0] Execute, [1] Memory, [2] Writeback.
    instr_t pipe[$];
    instr_t bubble;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit [1:0] fwd_of(bit [4:0] r);
        if (pipe[1].rw && pipe[1].rd != 0 && r == pipe[1].rd) return 2'b10;
        if (pipe[2].rw && pipe[2].rd != 0 && r == pipe[2].rd) return 2'b01;
        return 2'b00;
    endfunction

    task automatic step(bit rst, logic rw, logic mw, logic jmp, logic br, logic asrc,
                        logic [1:0] rsrc, logic [2:0] aluc, logic [4:0] rs1, logic [4:0] rs2,
                        logic [4:0] rd, logic zero, bit do_chk);
        instr_t e, m, w, nxt;
        bit     pcsrc, lw;
        @(negedge clk);
        reset           = rst;
        bus.RegWriteD   = rw;
        bus.MemWriteD   = mw;
        bus.JumpD       = jmp;
        bus.BranchD     = br;
        bus.ALUSrcD     = asrc;
        bus.ResultSrcD  = rsrc;
        bus.ALUControlD = aluc;
        bus.Rs1D        = rs1;
        bus.Rs2D        = rs2;
        bus.RdD         = rd;
        bus.ZeroE       = zero;
        #1;
        e     = pipe[0];
        m     = pipe[1];
        w     = pipe[2];
        pcsrc = (e.br && zero === 1'b1) || e.jmp;
        lw    = e.rw && e.rsrc == 2'b01 && e.rd != 0 && (rs1 == e.rd || rs2 == e.rd);
        if (do_chk) begin
            check("PCSrcE",      32'(bus.PCSrcE),      rst ? 32'd0 : 32'(pcsrc));
            check("FlushD",      32'(bus.FlushD),      rst ? 32'd0 : 32'(pcsrc));
            check("StallF",      32'(bus.StallF),      rst ? 32'd0 : 32'(lw));
            check("StallD",      32'(bus.StallD),      rst ? 32'd0 : 32'(lw));
            check("ForwardAE",   32'(bus.ForwardAE),   rst ? 32'd0 : 32'(fwd_of(e.rs1)));
            check("ForwardBE",   32'(bus.ForwardBE),   rst ? 32'd0 : 32'(fwd_of(e.rs2)));
            check("ALUControlE", 32'(bus.ALUControlE), 32'(e.aluc));
            check("ALUSrcE",     32'(bus.ALUSrcE),     32'(e.asrc));
            check("Rs1E",        32'(bus.Rs1E),        32'(e.rs1));
            check("Rs2E",        32'(bus.Rs2E),        32'(e.rs2));
            check("RdE",         32'(bus.RdE),         32'(e.rd));
            check("MemWriteM",   32'(bus.MemWriteM),   32'(m.mw));
            check("RegWriteM",   32'(bus.RegWriteM),   32'(m.rw));
            check("RdM",         32'(bus.RdM),         32'(m.rd));
            check("RegWriteW",   32'(bus.RegWriteW),   32'(w.rw));
            check("ResultSrcW",  32'(bus.ResultSrcW),  32'(w.rsrc));
            check("RdW",         32'(bus.RdW),         32'(w.rd));
        end
        if (rst) begin
            pipe = '{bubble, bubble, bubble};
        end else begin
            nxt      = bubble;
            if (!(lw || pcsrc)) begin
                nxt.rw   = (bus.RegWriteD === 1'b1);
                nxt.mw   = (bus.MemWriteD === 1'b1);
                nxt.jmp  = (bus.JumpD === 1'b1);
                nxt.br   = (bus.BranchD === 1'b1);
                nxt.asrc = bus.ALUSrcD;
                nxt.rsrc = $isunknown(bus.ResultSrcD) ? 2'b00 : bus.ResultSrcD;
                nxt.aluc = aluc;
                nxt.rs1  = rs1;
                nxt.rs2  = rs2;
                nxt.rd   = rd;
            end
            pipe.push_front(nxt);
            void'(pipe.pop_back());
        end
    endtask

    initial begin
        bubble = '{default: 0};
        pipe   = '{bubble, bubble, bubble};
        reset  = 1'b1;
        // First cycle only establishes known state.
        step(1, 1, 1, 1, 1, 1, 2'b01, 3'd5, 5'd7, 5'd7, 5'd7, 1, 0);
        step(1, 1, 0, 0, 1, 1, 2'b01, 3'd2, 5'd3, 5'd4, 5'd5, 1, 1);
        // add x3; lw x6; dependent use (stalled, held in D); branch taken; jump; unknown op.
        step(0, 1, 0, 0, 0, 0, 2'b00, 3'd0, 5'd1, 5'd2, 5'd3, 0, 1);
        step(0, 1, 0, 0, 0, 1, 2'b01, 3'd0, 5'd3, 5'd0, 5'd6, 0, 1);
        step(0, 1, 0, 0, 0, 0, 2'b00, 3'd0, 5'd3, 5'd6, 5'd5, 0, 1);
        step(0, 1, 0, 0, 0, 0, 2'b00, 3'd0, 5'd3, 5'd6, 5'd5, 0, 1);
        step(0, 0, 0, 0, 1, 0, 2'b00, 3'd1, 5'd5, 5'd6, 5'd0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 2'b00, 3'd0, 5'd5, 5'd3, 5'd8, 1, 1);
        step(0, 0, 0, 0, 1, 0, 2'b00, 3'd1, 5'd5, 5'd6, 5'd0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 5'd0, 5'd0, 5'd0, 0, 1);
        step(0, 1, 0, 1, 0, 0, 2'b10, 3'd0, 5'd0, 5'd0, 5'd1, 0, 1);
        step(0, 1'bx, 1'bx, 1'bx, 1'bx, 0, 2'bxx, 3'd7, 5'd9, 5'd10, 5'd11, 0, 1);
        step(0, 1'bx, 1'bx, 1'bx, 1'bx, 0, 2'bxx, 3'd7, 5'd9, 5'd10, 5'd11, 1, 1);
        step(0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 5'd0, 5'd0, 5'd0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 5'd0, 5'd0, 5'd0, 1, 1);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) == 0),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 6) == 0),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 3'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
